// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   - pc_src select encodings driven by the core controller
//   - canonical NOP used as the reset value of the instruction latch
//   - 2-bit fetch FSM state encoding
package fetch_pkg;

    localparam logic [1:0]  PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0]  PC_SRC_BR   = 2'b01;
    localparam logic [1:0]  PC_SRC_JALR = 2'b10;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_TRAP  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: combinational next-PC selection for the fetch stage.
// Ports:
//   pc          current architectural PC
//   pc_src      select: SEQ -> pc+4, BR -> pc+imm_ext, JALR -> alu_result
//               with bit0 cleared, reserved -> pc+4
//   imm_ext     sign-extended immediate
//   alu_result  jalr target (rs1+imm)
//   next_pc     unmasked next PC (adds wrap modulo 2^XLEN)
//   misaligned  next_pc[1:0] is non-zero
module pc_next_logic
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        next_pc = pc + XLEN'(4);
        case (pc_src)
            PC_SRC_BR:   next_pc = pc + imm_ext;
            PC_SRC_JALR: next_pc = {alu_result[XLEN-1:1], 1'b0};
            default:     ;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage, one instruction in flight, no prediction.
// Holds the PC, reads instruction memory over req/ack, presents instr/pc to
// decode and advances the PC when decode acknowledges.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pc_src, imm_ext, alu_result next-PC inputs, sampled on the instr_ack cycle
//   instr_ack                  decode consumed the presented instruction
//   imem_req, imem_addr        memory read request / address (== pc)
//   imem_ack, imem_rdata       memory response
//   instr, instr_valid, pc     instruction presented to decode
//   pc_plus4                   link value for jal/jalr
//   misalign                   sticky misaligned-target flag
// Build option: FETCH_MISALIGN_TRAP_EN enables the TRAP state and misalign
// flag; otherwise target low bits are silently masked and misalign is 0.
//
// state | meaning
// IDLE  | one cycle after reset release
// FETCH | imem_req high, waiting for imem_ack
// HOLD  | instruction valid to decode, waiting for instr_ack
// TRAP  | misaligned target taken (trap build only); left only via reset
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    input  logic            instr_ack,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign
);

    fetch_state_t    state;
    logic [XLEN-1:0] next_pc_raw;
    logic            next_misaligned;

    pc_next_logic #(.XLEN(XLEN)) u_pc_next (
        .pc         (pc),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .next_pc    (next_pc_raw),
        .misaligned (next_misaligned)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            instr      <= NOP_INSTR;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: if (imem_ack) begin
                    instr <= imem_rdata;
                    state <= ST_HOLD;
                end
                ST_HOLD:  if (instr_ack) begin
                    // The unmasked target is kept so the faulting address is visible.
                    pc <= next_pc_raw;
                    if (next_misaligned) begin
                        misalign_q <= 1'b1;
                        state      <= ST_TRAP;
                    end else begin
                        state      <= ST_FETCH;
                    end
                end
                ST_TRAP:  state <= ST_TRAP;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_low_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else begin
            case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: if (imem_ack) begin
                    instr <= imem_rdata;
                    state <= ST_HOLD;
                end
                ST_HOLD:  if (instr_ack) begin
                    pc    <= {next_pc_raw[XLEN-1:2], 2'b00};
                    state <= ST_FETCH;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Low target bits are dropped without a trap in this build.
    assign unused_low_bits = &{1'b0, next_misaligned, next_pc_raw[1:0]};
    assign misalign        = 1'b0;
`endif

    // Outputs depend only on registers, so there is no input-to-output path.
    assign imem_req    = (state == ST_FETCH);
    assign instr_valid = (state == ST_HOLD);
    assign imem_addr   = pc;
    assign pc_plus4    = pc + XLEN'(4);

endmodule
